// File: rtl/serial_adder.sv
// Bit-serial WIDTH-bit adder driving a single one-bit full adder stage, LSB first.
// Optional signed-overflow output enabled by defining SERIAL_ADDER_OVERFLOW_EN.

module full_adder_stage (
  input  logic a,
  input  logic b,
  input  logic carry_in,
  output logic sum,
  output logic carry_out
);
  assign sum       = a ^ b ^ carry_in;
  assign carry_out = (a & b) | (a & carry_in) | (b & carry_in);
endmodule

module serial_adder #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] operandA,
  input  logic [WIDTH-1:0] operandB,
  input  logic             carryIn,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             carryOut
`ifdef SERIAL_ADDER_OVERFLOW_EN
  ,
  output logic             overflow
`endif
);
  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {IDLE, ADD, DONE} state_t;

  state_t           state;
  logic [WIDTH-1:0] sh_a;
  logic [WIDTH-1:0] sh_b;
  logic [WIDTH-1:0] sh_s;
  logic             c_reg;
  logic [CW-1:0]    cnt;

  logic             bit_sum;
  logic             bit_carry;
  logic [WIDTH-1:0] next_s;

  full_adder_stage stage (
    .a         (sh_a[0]),
    .b         (sh_b[0]),
    .carry_in  (c_reg),
    .sum       (bit_sum),
    .carry_out (bit_carry)
  );

  // The new sum bit enters at the MSB so the LSB lands in bit 0 after WIDTH shifts.
  generate
    if (WIDTH == 1) begin : g_one
      assign next_s = bit_sum;
    end else begin : g_many
      assign next_s = {bit_sum, sh_s[WIDTH-1:1]};
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      busy     <= 1'b0;
      done     <= 1'b0;
      sh_a     <= '0;
      sh_b     <= '0;
      sh_s     <= '0;
      c_reg    <= 1'b0;
      cnt      <= '0;
      sum      <= '0;
      carryOut <= 1'b0;
`ifdef SERIAL_ADDER_OVERFLOW_EN
      overflow <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE, DONE: begin
          done <= 1'b0;
          if (start) begin
            sh_a  <= operandA;
            sh_b  <= operandB;
            c_reg <= carryIn;
            cnt   <= '0;
            state <= ADD;
            busy  <= 1'b1;
          end else begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        end
        ADD: begin
          sh_a  <= sh_a >> 1;
          sh_b  <= sh_b >> 1;
          sh_s  <= next_s;
          c_reg <= bit_carry;
          cnt   <= cnt + 1'b1;
          if (cnt == CW'(WIDTH - 1)) begin
            state    <= DONE;
            busy     <= 1'b0;
            done     <= 1'b1;
            sum      <= next_s;
            carryOut <= bit_carry;
`ifdef SERIAL_ADDER_OVERFLOW_EN
            // c_reg here is the carry into the MSB.
            overflow <= c_reg ^ bit_carry;
`endif
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_serial_adder.sv
// Directed self-checking bench for serial_adder (WIDTH=8), with immediate assertions.
// Overflow checks are active only when SERIAL_ADDER_OVERFLOW_EN is defined.

module tb_serial_adder;
  logic       clk = 1'b0;
  logic       reset;
  logic       start;
  logic [7:0] operand_a;
  logic [7:0] operand_b;
  logic       carry_in;
  logic       busy;
  logic       done;
  logic [7:0] sum;
  logic       carry_out;
`ifdef SERIAL_ADDER_OVERFLOW_EN
  logic       overflow;
`endif

  int compared   = 0;
  int mismatched = 0;

  int cycles;
  int busy_cycles;
  bit sum_changed;
  int done_count;

  always #5 clk = ~clk;

  serial_adder #(.WIDTH(8)) dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .operandA (operand_a),
    .operandB (operand_b),
    .carryIn  (carry_in),
    .busy     (busy),
    .done     (done),
    .sum      (sum),
    .carryOut (carry_out)
`ifdef SERIAL_ADDER_OVERFLOW_EN
    ,
    .overflow (overflow)
`endif
  );

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    compared++;
    assert (observed === expected) else begin
      mismatched++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
    end
  endtask

  // Drives one request; returns #1 after the accepting edge.
  task automatic applyStimulus(input logic [7:0] a, input logic [7:0] b,
                               input logic cin, input bit hold);
    @(negedge clk);
    operand_a = a;
    operand_b = b;
    carry_in  = cin;
    start     = 1'b1;
    @(posedge clk);
    #1;
    if (!hold) start = 1'b0;
  endtask

  // Counts edges until done is seen (bounded), tallying busy and sum movement.
  task automatic waitDone(output int n_cycles, output int n_busy, output bit changed);
    logic [7:0] held;
    held     = sum;
    n_busy   = busy ? 1 : 0;
    n_cycles = 0;
    changed  = 1'b0;
    while (n_cycles < 40) begin
      @(posedge clk);
      #1;
      n_cycles++;
      if (done) break;
      if (busy) n_busy++;
      if (sum !== held) changed = 1'b1;
    end
  endtask

  task automatic countDone(input int n, output int count);
    count = 0;
    repeat (n) begin
      @(posedge clk);
      #1;
      if (done) count++;
    end
  endtask

  initial begin
    reset     = 1'b1;
    start     = 1'b0;
    operand_a = '0;
    operand_b = '0;
    carry_in  = 1'b0;

    // Reset state, with start asserted to show reset wins.
    repeat (2) @(posedge clk);
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    checkOutput("reset_busy", busy, 0);
    checkOutput("reset_done", done, 0);
    checkOutput("reset_sum", sum, 0);
    checkOutput("reset_carry", carry_out, 0);
`ifdef SERIAL_ADDER_OVERFLOW_EN
    checkOutput("reset_ovf", overflow, 0);
`endif
    reset = 1'b0;
    @(posedge clk);
    #1;

    // 0x5A + 0x3C = 0x096
    applyStimulus(8'h5A, 8'h3C, 1'b0, 1'b0);
    waitDone(cycles, busy_cycles, sum_changed);
    checkOutput("t1_latency", cycles, 8);
    checkOutput("t1_busy_cycles", busy_cycles, 8);
    checkOutput("t1_sum", sum, 8'h96);
    checkOutput("t1_carry", carry_out, 0);
`ifdef SERIAL_ADDER_OVERFLOW_EN
    checkOutput("t1_ovf", overflow, 1);
`endif
    @(posedge clk);
    #1;
    checkOutput("t1_done_pulse", done, 0);
    checkOutput("t1_sum_hold", sum, 8'h96);

    // 0xFF + 0x01 = 0x100
    applyStimulus(8'hFF, 8'h01, 1'b0, 1'b0);
    waitDone(cycles, busy_cycles, sum_changed);
    checkOutput("t2_sum", sum, 8'h00);
    checkOutput("t2_carry", carry_out, 1);
`ifdef SERIAL_ADDER_OVERFLOW_EN
    checkOutput("t2_ovf", overflow, 0);
`endif

    // 0xFF + 0xFF + 1 = 0x1FF
    applyStimulus(8'hFF, 8'hFF, 1'b1, 1'b0);
    waitDone(cycles, busy_cycles, sum_changed);
    checkOutput("t3_sum", sum, 8'hFF);
    checkOutput("t3_carry", carry_out, 1);
`ifdef SERIAL_ADDER_OVERFLOW_EN
    checkOutput("t3_ovf", overflow, 0);
`endif

    // Back-to-back: start held through DONE picks up 0x80 + 0x80.
    applyStimulus(8'h01, 8'h02, 1'b0, 1'b1);
    operand_a = 8'h80;
    operand_b = 8'h80;
    carry_in  = 1'b0;
    waitDone(cycles, busy_cycles, sum_changed);
    checkOutput("b2b_first_latency", cycles, 8);
    checkOutput("b2b_first_sum", sum, 8'h03);
    checkOutput("b2b_first_carry", carry_out, 0);
    @(posedge clk);
    #1;
    start = 1'b0;
    checkOutput("b2b_reaccept_busy", busy, 1);
    waitDone(cycles, busy_cycles, sum_changed);
    checkOutput("b2b_done_spacing", cycles + 1, 9);
    checkOutput("b2b_sum_stable", sum_changed, 0);
    checkOutput("b2b_second_sum", sum, 8'h00);
    checkOutput("b2b_second_carry", carry_out, 1);
`ifdef SERIAL_ADDER_OVERFLOW_EN
    checkOutput("b2b_second_ovf", overflow, 1);
`endif
    @(posedge clk);
    #1;

    // Start during ADD must be ignored.
    applyStimulus(8'h10, 8'h20, 1'b0, 1'b0);
    repeat (2) begin
      @(posedge clk);
      #1;
    end
    operand_a = 8'hAA;
    operand_b = 8'h55;
    start     = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    waitDone(cycles, busy_cycles, sum_changed);
    checkOutput("busy_ign_latency", cycles, 5);
    checkOutput("busy_ign_sum", sum, 8'h30);
    checkOutput("busy_ign_carry", carry_out, 0);
    countDone(12, done_count);
    checkOutput("busy_ign_one_done", done_count, 0);

    // Reset at cycle 4 of ADD aborts the add.
    applyStimulus(8'h11, 8'h22, 1'b0, 1'b0);
    repeat (3) begin
      @(posedge clk);
      #1;
    end
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    checkOutput("abort_busy", busy, 0);
    checkOutput("abort_done", done, 0);
    checkOutput("abort_sum", sum, 8'h00);
    checkOutput("abort_carry", carry_out, 0);
    countDone(12, done_count);
    checkOutput("abort_no_done", done_count, 0);

    applyStimulus(8'h05, 8'h06, 1'b1, 1'b0);
    waitDone(cycles, busy_cycles, sum_changed);
    checkOutput("post_abort_latency", cycles, 8);
    checkOutput("post_abort_sum", sum, 8'h0C);
    checkOutput("post_abort_carry", carry_out, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
